// File: rtl/mma_pkg.sv
// Shared definitions for the MMA command front end: FSM states, command
// opcodes, register indices and response status codes.
package mma_pkg;

  // Front-end FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESP   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_BUSY   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Command opcodes carried on cmd_op.
  localparam logic [1:0] OP_WR_REG  = 2'b00;
  localparam logic [1:0] OP_RD_REG  = 2'b01;
  localparam logic [1:0] OP_START   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  // Response status codes carried on rsp_err.
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_MISSING = 2'b10;
  localparam logic [1:0] ERR_BUSY    = 2'b11;

  // Register indices. Indices above REG_FLAGS are unmapped.
  localparam logic [3:0] REG_LHS_BASE         = 4'd0;
  localparam logic [3:0] REG_RHS_BASE         = 4'd1;
  localparam logic [3:0] REG_DST_BASE         = 4'd2;
  localparam logic [3:0] REG_BIAS_BASE        = 4'd3;
  localparam logic [3:0] REG_Q_MULT_PT        = 4'd4;
  localparam logic [3:0] REG_Q_SHIFT_PT       = 4'd5;
  localparam logic [3:0] REG_K                = 4'd6;
  localparam logic [3:0] REG_N                = 4'd7;
  localparam logic [3:0] REG_M                = 4'd8;
  localparam logic [3:0] REG_LHS_ROW_STRIDE_B = 4'd9;
  localparam logic [3:0] REG_DST_ROW_STRIDE_B = 4'd10;
  localparam logic [3:0] REG_RHS_COL_STRIDE_B = 4'd11;
  localparam logic [3:0] REG_FLAGS            = 4'd12;

  // Number of full 32-bit configuration words (indices 0..11).
  localparam int NUM_WORD_REGS = 12;

  // True when the index addresses a mapped register.
  function automatic logic reg_addr_valid(input logic [3:0] addr);
    return (addr <= REG_FLAGS);
  endfunction

endpackage

// File: rtl/mma_cmd_frontend_if.sv
// Command/response channel bundle between a host and mma_cmd_frontend.
//
// Handshake: each channel transfers on the rising clk edge where valid and
// ready are both 1. The source holds valid and its payload stable until that
// edge; the sink may drive ready independently of valid.
interface mma_cmd_frontend_if;
  import mma_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;

  // Host side: issues commands, consumes responses.
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  // Front-end side: accepts commands, produces responses.
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/mma_cfg_regfile.sv
// Configuration register storage with a combinational read mux.
// Twelve 32-bit words plus a two-bit flags register; unmapped indices read 0
// and ignore writes.
module mma_cfg_regfile
  import mma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] lhs_base,
  output logic [31:0] rhs_base,
  output logic [31:0] dst_base,
  output logic [31:0] bias_base,
  output logic [31:0] q_mult_pt,
  output logic [31:0] q_shift_pt,
  output logic [31:0] k,
  output logic [31:0] n,
  output logic [31:0] m,
  output logic [31:0] lhs_row_stride_b,
  output logic [31:0] dst_row_stride_b,
  output logic [31:0] rhs_col_stride_b,
  output logic        use_per_channel,
  output logic        cfg_16bits_ia
);

  logic [31:0] regs_q [NUM_WORD_REGS];
  logic [31:0] regs_d [NUM_WORD_REGS];
  logic [1:0]  flags_q;
  logic [1:0]  flags_d;

  // Next-state of the register array: at most one location changes per write.
  always_comb begin
    regs_d  = regs_q;
    flags_d = flags_q;
    if (wr_en) begin
      if (wr_addr == REG_FLAGS) begin
        flags_d = wr_data[1:0];
      end else if (wr_addr < REG_FLAGS) begin
        regs_d[wr_addr] = wr_data;
      end
    end
  end

  // Register storage, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORD_REGS; i++) begin
        regs_q[i] <= '0;
      end
      flags_q <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end

  // Read mux; flags occupy the two LSBs and the upper bits read 0.
  always_comb begin
    rd_data = '0;
    if (rd_addr < REG_FLAGS) begin
      rd_data = regs_q[rd_addr];
    end else if (rd_addr == REG_FLAGS) begin
      rd_data = {30'd0, flags_q};
    end
  end

  assign lhs_base         = regs_q[REG_LHS_BASE];
  assign rhs_base         = regs_q[REG_RHS_BASE];
  assign dst_base         = regs_q[REG_DST_BASE];
  assign bias_base        = regs_q[REG_BIAS_BASE];
  assign q_mult_pt        = regs_q[REG_Q_MULT_PT];
  assign q_shift_pt       = regs_q[REG_Q_SHIFT_PT];
  assign k                = regs_q[REG_K];
  assign n                = regs_q[REG_N];
  assign m                = regs_q[REG_M];
  assign lhs_row_stride_b = regs_q[REG_LHS_ROW_STRIDE_B];
  assign dst_row_stride_b = regs_q[REG_DST_ROW_STRIDE_B];
  assign rhs_col_stride_b = regs_q[REG_RHS_COL_STRIDE_B];
  assign use_per_channel  = flags_q[0];
  assign cfg_16bits_ia    = flags_q[1];

endmodule

// File: rtl/mma_cmd_frontend.sv
// MMA command front end: decodes host register/start commands, launches the
// matrix controller and returns one response per command.
// Optional feature: define MMA_CMD_PERF_CNT_EN to count BUSY cycles and
// return the count in the START response.
module mma_cmd_frontend
  import mma_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  mma_cmd_frontend_if.slave   bus,
  output logic                calc_start,
  input  logic                sa_ready,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [1:0]          err_code,
  output logic [31:0]         lhs_base,
  output logic [31:0]         rhs_base,
  output logic [31:0]         dst_base,
  output logic [31:0]         bias_base,
  output logic [31:0]         q_mult_pt,
  output logic [31:0]         q_shift_pt,
  output logic [31:0]         k,
  output logic [31:0]         n,
  output logic [31:0]         m,
  output logic [31:0]         lhs_row_stride_b,
  output logic [31:0]         dst_row_stride_b,
  output logic [31:0]         rhs_col_stride_b,
  output logic                use_per_channel,
  output logic                cfg_16bits_ia,
  output state_e              dbg_state
);

  state_e      state_q;
  state_e      state_d;
  logic [31:0] rsp_data_q;
  logic [31:0] rsp_data_d;
  logic [1:0]  rsp_err_q;
  logic [1:0]  rsp_err_d;

  logic        cmd_accept;
  logic        addr_ok;
  logic        wr_en;
  logic [31:0] rd_data;
  logic [31:0] done_count;

  assign cmd_accept = (state_q == ST_IDLE) && bus.cmd_valid;
  assign addr_ok    = reg_addr_valid(bus.cmd_addr);
  assign wr_en      = cmd_accept && (bus.cmd_op == OP_WR_REG) && addr_ok;

  mma_cfg_regfile u_regfile (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (wr_en),
    .wr_addr          (bus.cmd_addr),
    .wr_data          (bus.cmd_wdata),
    .rd_addr          (bus.cmd_addr),
    .rd_data          (rd_data),
    .lhs_base         (lhs_base),
    .rhs_base         (rhs_base),
    .dst_base         (dst_base),
    .bias_base        (bias_base),
    .q_mult_pt        (q_mult_pt),
    .q_shift_pt       (q_shift_pt),
    .k                (k),
    .n                (n),
    .m                (m),
    .lhs_row_stride_b (lhs_row_stride_b),
    .dst_row_stride_b (dst_row_stride_b),
    .rhs_col_stride_b (rhs_col_stride_b),
    .use_per_channel  (use_per_channel),
    .cfg_16bits_ia    (cfg_16bits_ia)
  );

`ifdef MMA_CMD_PERF_CNT_EN
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [31:0] cnt_inc;

  // BUSY-cycle counter: cleared on launch, saturating increment while busy.
  always_comb begin
    cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    cnt_d   = cnt_q;
    if (state_q == ST_LAUNCH) begin
      cnt_d = '0;
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_inc;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The completion cycle itself is a BUSY cycle, so report the incremented value.
  assign done_count = cnt_inc;
`else
  assign done_count = '0;
`endif

  // FSM state and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rsp_data_q <= '0;
      rsp_err_q  <= ERR_OK;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if ((bus.cmd_op == OP_START) && sa_ready) begin
            state_d = ST_LAUNCH;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP, ST_DONE: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: state_d = ST_BUSY;
      ST_BUSY: begin
        if (wb_valid) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state, plus next values of the response payload.
  always_comb begin
    bus.cmd_ready = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_RESP) || (state_q == ST_DONE);
    calc_start    = (state_q == ST_LAUNCH);
    wb_ready      = (state_q == ST_BUSY);

    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (cmd_accept) begin
      rsp_data_d = '0;
      case (bus.cmd_op)
        OP_WR_REG: rsp_err_d = addr_ok ? ERR_OK : ERR_ILLEGAL;
        OP_RD_REG: begin
          rsp_err_d  = addr_ok ? ERR_OK : ERR_ILLEGAL;
          rsp_data_d = addr_ok ? rd_data : '0;
        end
        OP_START:  rsp_err_d = sa_ready ? ERR_OK : ERR_BUSY;
        default:   rsp_err_d = ERR_ILLEGAL;
      endcase
    end else if ((state_q == ST_BUSY) && wb_valid) begin
      rsp_data_d = done_count;
      rsp_err_d  = err_code;
    end else if (bus.rsp_valid && bus.rsp_ready) begin
      // Clear after delivery so the idle bus carries no stale payload.
      rsp_data_d = '0;
      rsp_err_d  = ERR_OK;
    end
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mma_cmd_frontend.sv
// Directed bench for mma_cmd_frontend: register access, illegal commands,
// START with controller completion, busy rejection, reset in BUSY and
// response back-pressure.
module tb_mma_cmd_frontend;
  import mma_pkg::*;

`ifdef MMA_CMD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        calc_start;
  logic        sa_ready;
  logic        wb_valid;
  logic        wb_ready;
  logic [1:0]  err_code;
  logic [31:0] lhs_base, rhs_base, dst_base, bias_base, q_mult_pt, q_shift_pt;
  logic [31:0] k, n, m, lhs_row_stride_b, dst_row_stride_b, rhs_col_stride_b;
  logic        use_per_channel, cfg_16bits_ia;
  state_e      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  mma_cmd_frontend_if bus_if ();

  mma_cmd_frontend dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus_if),
    .calc_start       (calc_start),
    .sa_ready         (sa_ready),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .err_code         (err_code),
    .lhs_base         (lhs_base),
    .rhs_base         (rhs_base),
    .dst_base         (dst_base),
    .bias_base        (bias_base),
    .q_mult_pt        (q_mult_pt),
    .q_shift_pt       (q_shift_pt),
    .k                (k),
    .n                (n),
    .m                (m),
    .lhs_row_stride_b (lhs_row_stride_b),
    .dst_row_stride_b (dst_row_stride_b),
    .rhs_col_stride_b (rhs_col_stride_b),
    .use_per_channel  (use_per_channel),
    .cfg_16bits_ia    (cfg_16bits_ia),
    .dbg_state        (dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command; it is accepted on the next edge.
  task automatic send(input logic [1:0] op, input logic [3:0] addr, input logic [31:0] data);
    bus_if.cmd_op    = op;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_wdata = data;
    bus_if.cmd_valid = 1'b1;
    chk("cmd_ready_before_accept", 32'(bus_if.cmd_ready), 32'd1);
    step();
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_wdata = '0;
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] data, input logic [1:0] err);
    chk({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'd1);
    chk({tag, "_rsp_data"}, bus_if.rsp_data, data);
    chk({tag, "_rsp_err"}, 32'(bus_if.rsp_err), 32'(err));
  endtask

  task automatic finish_rsp(input string tag);
    bus_if.rsp_ready = 1'b1;
    step();
    bus_if.rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_drop"}, 32'(bus_if.rsp_valid), 32'd0);
    chk({tag, "_back_to_idle"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // START with the controller completing d cycles after calc_start (d >= 1).
  task automatic run_start(input string tag, input int d, input logic [1:0] ec);
    int pulses;
    pulses   = 0;
    sa_ready = 1'b1;
    send(OP_START, 4'd0, 32'd0);
    chk({tag, "_launch_state"}, 32'(dbg_state), 32'(ST_LAUNCH));
    chk({tag, "_calc_start_hi"}, 32'(calc_start), 32'd1);
    pulses += int'(calc_start);
    step();
    chk({tag, "_wb_ready_busy"}, 32'(wb_ready), 32'd1);
    for (int i = 1; i < d; i++) begin
      pulses += int'(calc_start);
      step();
    end
    pulses  += int'(calc_start);
    wb_valid = 1'b1;
    err_code = ec;
    step();
    wb_valid = 1'b0;
    err_code = 2'b00;
    chk({tag, "_calc_start_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_wb_ready_done"}, 32'(wb_ready), 32'd0);
    check_rsp(tag, PERF ? 32'(d) : 32'd0, ec);
    finish_rsp(tag);
  endtask

  // Directed sequence.
  initial begin
    rst              = 1'b1;
    sa_ready         = 1'b0;
    wb_valid         = 1'b0;
    err_code         = 2'b00;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = 2'b00;
    bus_if.cmd_addr  = 4'd0;
    bus_if.cmd_wdata = '0;
    bus_if.rsp_ready = 1'b0;

    repeat (3) step();
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst_calc_start", 32'(calc_start), 32'd0);
    chk("rst_wb_ready", 32'(wb_ready), 32'd0);
    chk("rst_k", k, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);

    // Write k then read it back; each response one cycle after accept.
    send(OP_WR_REG, REG_K, 32'h10);
    check_rsp("wr_k", 32'd0, ERR_OK);
    chk("wr_k_output", k, 32'h10);
    finish_rsp("wr_k");
    send(OP_RD_REG, REG_K, 32'd0);
    check_rsp("rd_k", 32'h10, ERR_OK);
    finish_rsp("rd_k");

    // Word 0 and flags register (upper flag bits read 0).
    send(OP_WR_REG, REG_LHS_BASE, 32'hDEAD_BEEF);
    finish_rsp("wr_lhs");
    chk("lhs_base_output", lhs_base, 32'hDEAD_BEEF);
    send(OP_WR_REG, REG_FLAGS, 32'hFFFF_FFFF);
    finish_rsp("wr_flags");
    chk("use_per_channel", 32'(use_per_channel), 32'd1);
    chk("cfg_16bits_ia", 32'(cfg_16bits_ia), 32'd1);
    send(OP_RD_REG, REG_FLAGS, 32'd0);
    check_rsp("rd_flags", 32'h3, ERR_OK);
    finish_rsp("rd_flags");

    // Unmapped addresses and the illegal opcode.
    send(OP_RD_REG, 4'd14, 32'd0);
    check_rsp("rd_addr14", 32'd0, ERR_ILLEGAL);
    finish_rsp("rd_addr14");
    send(OP_WR_REG, 4'd13, 32'h1234_5678);
    check_rsp("wr_addr13", 32'd0, ERR_ILLEGAL);
    finish_rsp("wr_addr13");
    send(OP_ILLEGAL, REG_K, 32'h0000_0099);
    check_rsp("op_illegal", 32'd0, ERR_ILLEGAL);
    finish_rsp("op_illegal");
    chk("k_unchanged", k, 32'h10);
    chk("lhs_unchanged", lhs_base, 32'hDEAD_BEEF);

    // Stray completion outside BUSY is ignored.
    wb_valid = 1'b1;
    chk("stray_wb_ready", 32'(wb_ready), 32'd0);
    step();
    wb_valid = 1'b0;
    chk("stray_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("stray_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);

    // START completions.
    run_start("start_ok", 20, ERR_OK);
    run_start("start_missing", 3, ERR_MISSING);

    // START while controller busy.
    sa_ready = 1'b0;
    send(OP_START, 4'd0, 32'd0);
    chk("start_busy_calc_start", 32'(calc_start), 32'd0);
    chk("start_busy_state", 32'(dbg_state), 32'(ST_RESP));
    check_rsp("start_busy", 32'd0, ERR_BUSY);
    chk("start_busy_calc_start2", 32'(calc_start), 32'd0);
    finish_rsp("start_busy");

    // Response back-pressure: payload held stable, no new command accepted.
    send(OP_WR_REG, REG_N, 32'h55);
    finish_rsp("wr_n");
    send(OP_RD_REG, REG_N, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check_rsp("hold", 32'h55, ERR_OK);
      chk("hold_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
      step();
    end
    check_rsp("hold_end", 32'h55, ERR_OK);
    finish_rsp("hold");

    // Reset while BUSY.
    sa_ready = 1'b1;
    send(OP_START, 4'd0, 32'd0);
    step();
    step();
    chk("pre_rst_busy", 32'(dbg_state), 32'(ST_BUSY));
    rst = 1'b1;
    #1;
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mid_rst_wb_ready", 32'(wb_ready), 32'd0);
    chk("mid_rst_calc_start", 32'(calc_start), 32'd0);
    chk("mid_rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("mid_rst_rsp_data", bus_if.rsp_data, 32'd0);
    chk("mid_rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
    chk("mid_rst_lhs", lhs_base, 32'd0);
    chk("mid_rst_n", n, 32'd0);
    chk("mid_rst_flags", 32'({cfg_16bits_ia, use_per_channel}), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst2_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    send(OP_RD_REG, REG_LHS_BASE, 32'd0);
    check_rsp("rd_lhs_after_rst", 32'd0, ERR_OK);
    finish_rsp("rd_lhs_after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mma_cmd_frontend.md
MMA_CMD_FRONTEND -- requirements
Module: mma_cmd_frontend

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  clock; rst  in  1  async reset, active-high.
REQ-002 SHALL have these command-side ports:
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted
- cmd_op  in  2  00 WR_REG, 01 RD_REG, 10 START, 11 illegal
- cmd_addr  in  4  register index
- cmd_wdata  in  32  write data
REQ-003 SHALL have these response-side ports:
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_data  out  32  read data or cycle count
- rsp_err  out  2  status: 00 ok, 01 illegal, 10 resource missing, 11 busy
REQ-004 SHALL have these controller-side ports:
- calc_start  out  1  start pulse
- sa_ready  in  1  controller idle
- wb_valid  in  1  completion valid
- wb_ready  out  1  completion accepted
- err_code  in  2  completion status
REQ-005 SHALL drive these controller config outputs, one per register: lhs_base, rhs_base, dst_base, bias_base, q_mult_pt, q_shift_pt, k, n, m, lhs_row_stride_b, dst_row_stride_b, rhs_col_stride_b (each out 32); use_per_channel, cfg_16bits_ia (each out 1).

Function
REQ-006 Register map SHALL be:
- 0 lhs_base, 1 rhs_base, 2 dst_base, 3 bias_base
- 4 q_mult_pt, 5 q_shift_pt
- 6 k, 7 n, 8 m
- 9 lhs_row_stride_b, 10 dst_row_stride_b, 11 rhs_col_stride_b
- 12 flags: bit0 use_per_channel, bit1 cfg_16bits_ia; other bits read 0
- 13-15 invalid
REQ-007 FSM states SHALL be IDLE, RESP, LAUNCH, BUSY, DONE.
REQ-008 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid&&cmd_ready.
REQ-009 WR_REG to a valid address SHALL update the register on the accept edge; FSM goes to RESP with rsp_err=00, rsp_data=0.
REQ-010 RD_REG to a valid address SHALL go to RESP with rsp_data = register value and rsp_err=00.
REQ-011 An illegal op or an address of 13-15 SHALL cause no side effect; FSM goes to RESP with rsp_err=01, rsp_data=0.
REQ-012 START with sa_ready=0 SHALL go to RESP with rsp_err=11; START with sa_ready=1 SHALL go to LAUNCH.
REQ-013 In LAUNCH, calc_start SHALL be registered high for exactly one cycle, then FSM goes to BUSY.
REQ-014 wb_ready SHALL be 1 exactly while in BUSY; on wb_valid&&wb_ready, err_code SHALL be captured and FSM goes to DONE.
REQ-015 In RESP/DONE, rsp_valid SHALL be 1 and rsp_data/rsp_err held stable until rsp_ready; then FSM returns to IDLE.
REQ-016 Response latency SHALL be: register ops present rsp_valid the cycle after accept; START presents rsp_valid the cycle after the wb handshake.
REQ-017 Config outputs SHALL be driven directly from registers and SHALL be stable from LAUNCH to DONE, since no writes are accepted outside IDLE.
REQ-018 If wb_valid rises outside BUSY, it SHALL be ignored (wb_ready=0).

Reset
REQ-019 On rst, all registers, calc_start, wb_ready, rsp_valid, rsp_data and rsp_err SHALL be 0, and FSM SHALL be IDLE, including mid-operation; cmd_ready=1 after release.

Configuration
REQ-020 With MMA_CMD_PERF_CNT_EN defined, a 32-bit counter SHALL clear in LAUNCH and increment each BUSY cycle, saturating at 0xFFFFFFFF; the START response rsp_data SHALL be the count.
REQ-021 Without MMA_CMD_PERF_CNT_EN, no counter SHALL exist and the START response rsp_data SHALL be 0.

Structure
REQ-022 The shared package mma_pkg SHALL hold the FSM state enum, cmd_op encodings, register index constants and rsp_err codes.
REQ-023 One sub-module, mma_cfg_regfile (register storage plus read mux), SHALL be used; the FSM and counter SHALL stay in the top module.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- WR_REG addr 6 data 0x10, then RD_REG addr 6 -> rsp_data=0x10, rsp_err=00, each response 1 cycle after accept.
- RD_REG addr 14 -> rsp_err=01, no register change; cmd_op=11 -> rsp_err=01.
- START with sa_ready=1, controller model raises wb_valid 20 cycles after calc_start with err_code=00 -> single-cycle calc_start; rsp_err=00; rsp_data=20 with the macro, 0 without.
- START, model completes with err_code=10 -> rsp_err=10.
- START with sa_ready=0 -> rsp_err=11, calc_start never asserted.
- rst asserted in BUSY -> all outputs 0, IDLE; a subsequent RD_REG addr 0 returns 0.
- rsp_ready held low 5 cycles -> rsp_valid, rsp_data and rsp_err stable; cmd_ready=0 throughout.
